// File: rtl/remote_comm.sv
// UART command/response link: sends a 16-bit command as two 8N1 bytes (high first)
// and receives 8N1 response bytes on RX; both directions run independently.
module remote_comm #(
    parameter int unsigned BAUD_CYC = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam int unsigned FIRST_CYC = (BAUD_CYC * 3) / 2;
    localparam int unsigned CW        = $clog2(FIRST_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // ---------------- transmitter ----------------
    tx_state_e       tx_state_q, tx_state_d;
    logic [7:0]      cmd_lo_q, cmd_lo_d;
    logic [8:0]      tx_sh_q, tx_sh_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic            tx_q, tx_d;
    logic            cmd_snt_q, cmd_snt_d;
    logic            accept;
    logic            tx_bit_end;

    assign accept     = (tx_state_q == IDLE) && snd_cmd;
    assign tx_bit_end = (tx_cnt_q == CW'(BAUD_CYC - 1));

    // The high byte goes straight into the shift register, so only the low byte needs holding.
    always_comb begin
        tx_state_d = tx_state_q;
        cmd_lo_d   = cmd_lo_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_cnt_d   = tx_cnt_q;
        tx_d       = tx_q;
        cmd_snt_d  = cmd_snt_q;
        case (tx_state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (snd_cmd) begin
                    cmd_lo_d   = cmd[7:0];
                    cmd_snt_d  = 1'b0;
                    tx_state_d = HIGH;
                    tx_d       = 1'b0;
                    tx_sh_d    = {1'b1, cmd[15:8]};
                    tx_bit_d   = '0;
                    tx_cnt_d   = '0;
                end
            end
            HIGH, LOW: begin
                if (tx_bit_end) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'd9) begin
                        if (tx_state_q == HIGH) begin
                            tx_state_d = LOW;
                            tx_d       = 1'b0;
                            tx_sh_d    = {1'b1, cmd_lo_q};
                            tx_bit_d   = '0;
                        end else begin
                            tx_state_d = IDLE;
                            tx_d       = 1'b1;
                            cmd_snt_d  = 1'b1;
                        end
                    end else begin
                        tx_d     = tx_sh_q[0];
                        tx_sh_d  = {1'b1, tx_sh_q[8:1]};
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: begin
                tx_state_d = IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            cmd_lo_q   <= '0;
            tx_sh_q    <= '1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
            tx_q       <= 1'b1;
            cmd_snt_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            cmd_lo_q   <= cmd_lo_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_q       <= tx_d;
            cmd_snt_q  <= cmd_snt_d;
        end
    end

    assign TX      = tx_q;
    assign cmd_snt = cmd_snt_q;

    // ---------------- receiver ----------------
    rx_state_e       rx_state_q, rx_state_d;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic [7:0]      resp_q, resp_d;
    logic            resp_rdy_q, resp_rdy_d;
    logic            start_edge;

    assign start_edge = rx_prev_q & ~rx_sync_q;

    // The byte is delivered at mid stop bit so a back-to-back start edge is never missed.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q;
        if (accept) begin
            resp_rdy_d = 1'b0;
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (start_edge) begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = CW'(FIRST_CYC - 1);
                    rx_bit_d   = '0;
                    resp_rdy_d = 1'b0;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                    rx_cnt_d = CW'(BAUD_CYC - 1);
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    resp_d     = rx_sh_q;
                    resp_rdy_d = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
        end else begin
            rx_meta_q  <= RX;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
        end
    end

    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Directed-plus-random bench for remote_comm: decodes TX frames, drives RX frames,
// and compares against a byte-level model of the command/response link.
module tb_remote_comm;

    localparam int unsigned B = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_drv = 1'b1;
    logic        loop = 1'b0;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = '0;
    logic        RX, TX, cmd_snt, resp_rdy;
    logic [7:0]  resp;

    assign RX = loop ? TX : rx_drv;

    remote_comm #(.BAUD_CYC(B)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd),
        .snd_cmd(snd_cmd), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int mon_bad = 0;
    int snt_rises = 0;
    int rdy_rises = 0;
    logic [7:0] txq[$];

    always @(posedge cmd_snt) snt_rises++;
    always @(posedge resp_rdy) rdy_rises++;

    // Line decoder: samples each bit of an 8N1 frame at its middle
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge TX);
            if (rst_n) begin
                repeat (B / 2) @(negedge clk);
                if (TX === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (B) @(negedge clk);
                        b[i] = TX;
                    end
                    repeat (B) @(negedge clk);
                    if (TX !== 1'b1) mon_bad++;
                    txq.push_back(b);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic send(input logic [15:0] v);
        @(negedge clk);
        cmd = v;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
    endtask

    task automatic wait_snt(input string tag, output int k);
        k = 0;
        while (!cmd_snt && k < int'(25 * B)) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_snt"}, cmd_snt, 1'b1);
    endtask

    task automatic expect_tx(input string tag, input logic [15:0] v);
        check({tag, "_nbytes"}, txq.size(), 2);
        if (txq.size() == 2) begin
            check({tag, "_hi"}, txq[0], v[15:8]);
            check({tag, "_lo"}, txq[1], v[7:0]);
        end
        txq.delete();
    endtask

    // Full command transaction: latency window and decoded bytes
    task automatic do_cmd(input string tag, input logic [15:0] v);
        int k;
        send(v);
        check({tag, "_snt_clr"}, cmd_snt, 1'b0);
        wait_snt(tag, k);
        check_rng({tag, "_lat"}, k, 20 * B - 3, 20 * B + 3);
        repeat (4) @(negedge clk);
        expect_tx(tag, v);
    endtask

    task automatic rx_frame(input logic [7:0] d, output int drop_at, output int rise_at,
                            output logic [7:0] resp_at_drop);
        logic [9:0] f;
        int n;
        f = {1'b1, d, 1'b0};
        n = 0;
        drop_at = -1;
        rise_at = -1;
        resp_at_drop = '0;
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            for (int j = 0; j < int'(B); j++) begin
                @(negedge clk);
                n++;
                if (!resp_rdy && drop_at < 0) begin
                    drop_at = n;
                    resp_at_drop = resp;
                end
                if (resp_rdy && drop_at >= 0 && rise_at < 0) rise_at = n;
            end
        end
    endtask

    initial begin
        int k, dr, ri;
        logic [7:0] rd, d;
        logic [15:0] v;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx", TX, 1'b1);
        check("rst_snt", cmd_snt, 1'b0);
        check("rst_rdy", resp_rdy, 1'b0);
        check("rst_resp", resp, 8'h00);
        rst_n = 1'b1;
        repeat (3 * B) @(negedge clk);
        check("idle_noframe", txq.size(), 0);

        do_cmd("c7020", 16'h7020);
        repeat (2 * B) @(negedge clk);
        check("c7020_hold", cmd_snt, 1'b1);

        rx_frame(8'hA5, dr, ri, rd);
        check("rxA5_resp", resp, 8'hA5);
        check("rxA5_rdy", resp_rdy, 1'b1);
        check_rng("rxA5_lat", ri, (19 * B) / 2, 10 * B + 3);
        rx_frame(8'h5A, dr, ri, rd);
        check_rng("rx5A_drop", dr, 1, B / 2);
        check("rx5A_hold", rd, 8'hA5);
        check("rx5A_resp", resp, 8'h5A);
        check("rx5A_rdy", resp_rdy, 1'b1);

        // accepted command clears a pending response
        send(16'h0000);
        check("snd_clr_rdy", resp_rdy, 1'b0);
        check("snd_keep_resp", resp, 8'h5A);
        wait_snt("c0000", k);
        repeat (4) @(negedge clk);
        expect_tx("c0000", 16'h0000);

        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            rx_frame(d, dr, ri, rd);
            check("rnd_rx_resp", resp, d);
            check("rnd_rx_rdy", resp_rdy, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            v = 16'($urandom);
            do_cmd("rnd_cmd", v);
        end

        // full duplex: command and response overlap
        v = 16'($urandom);
        d = 8'($urandom_range(0, 255));
        fork
            do_cmd("dup_cmd", v);
            begin
                repeat (B) @(negedge clk);
                rx_frame(d, dr, ri, rd);
            end
        join
        check("dup_resp", resp, d);

        // snd_cmd during HIGH byte is ignored
        snt_rises = 0;
        send(16'h0601);
        repeat (3 * B) @(negedge clk);
        cmd = 16'hFFFF;
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        wait_snt("ign", k);
        repeat (12 * B) @(negedge clk);
        expect_tx("ign", 16'h0601);
        check("ign_rises", snt_rises, 1);

        // loopback
        loop = 1'b1;
        rdy_rises = 0;
        send(16'h1234);
        wait_snt("loop", k);
        repeat (4) @(negedge clk);
        check("loop_rises", rdy_rises, 2);
        check("loop_resp", resp, 8'h34);
        check("loop_snt", cmd_snt, 1'b1);
        expect_tx("loop", 16'h1234);
        loop = 1'b0;
        repeat (B) @(negedge clk);

        // reset mid LOW byte
        send(16'h5555);
        repeat (14 * B) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_tx", TX, 1'b1);
        check("mrst_snt", cmd_snt, 1'b0);
        check("mrst_rdy", resp_rdy, 1'b0);
        check("mrst_resp", resp, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * B) @(negedge clk);
        txq.delete();
        repeat (3 * B) @(negedge clk);
        check("mrst_noframe", txq.size(), 0);
        check("mrst_idle_tx", TX, 1'b1);
        do_cmd("cABCD", 16'hABCD);

        check("stop_bits", mon_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/remote_comm.md
REMOTE_COMM -- requirements
Module: remote_comm

Interface
REQ-001 The module SHALL have parameter BAUD_CYC, default 434, meaning clocks per UART bit (115200 baud at 50 MHz).
REQ-002 The module SHALL have port clk  input  1  system clock; all logic is clocked on the rising edge.
REQ-003 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The module SHALL have port RX  input  1  UART serial in, asynchronous to clk, idle high.
REQ-005 The module SHALL have port TX  output  1  UART serial out, idle high.
REQ-006 The module SHALL have port cmd  input  16  command word to send.
REQ-007 The module SHALL have port snd_cmd  input  1  one-cycle request to send cmd.
REQ-008 The module SHALL have port cmd_snt  output  1  high once both command bytes are fully transmitted.
REQ-009 The module SHALL have port resp_rdy  output  1  high when a received response byte is valid.
REQ-010 The module SHALL have port resp  output  8  last received response byte.

Function
REQ-011 The module SHALL use one clock domain and asynchronous active-low reset only.
REQ-012 UART framing SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit BAUD_CYC clocks.
REQ-013 On snd_cmd while idle, cmd SHALL be latched and cmd_snt cleared on that same edge.
REQ-014 The high byte cmd[15:8] SHALL be transmitted first, then the low byte cmd[7:0].
REQ-015 The low byte's start bit SHALL follow the high byte's stop bit with no idle gap beyond 2 clocks.
REQ-016 The controller SHALL be an FSM with states IDLE, HIGH (high byte in flight) and LOW (low byte in flight).
REQ-017 FSM transitions: IDLE->HIGH on snd_cmd; HIGH->LOW at high-byte stop-bit end; LOW->IDLE at low-byte stop-bit end.
REQ-018 cmd_snt SHALL be set on the LOW->IDLE transition and held until the next accepted snd_cmd.
REQ-019 snd_cmd asserted in HIGH or LOW SHALL be ignored; the latched cmd and the TX waveform stay unchanged.
REQ-020 TX SHALL be driven from a flop, so it is glitch-free.
REQ-021 RX SHALL be double-flop synchronized before use.
REQ-022 The receiver SHALL detect the start bit on the synchronized falling edge of RX.
REQ-023 After start-bit detection, each bit SHALL be sampled at its mid-point: first sample BAUD_CYC*1.5 clocks after the falling edge, then every BAUD_CYC clocks.
REQ-024 After the 8th data bit is sampled and the stop-bit period ends, resp SHALL be loaded with the byte and resp_rdy set.
REQ-025 The stop-bit value SHALL not be checked; there is no framing error output.
REQ-026 resp_rdy SHALL stay high until the next start bit is detected or the next snd_cmd is accepted, whichever comes first.
REQ-027 resp SHALL hold its value until the next complete reception.
REQ-028 TX and RX paths SHALL be fully independent (full duplex); reception during transmission is supported.
REQ-029 Baud and bit counters SHALL be sized for BAUD_CYC*1.5 without overflow (at least 10 bits at the default).

Reset
REQ-030 While rst_n=0: TX=1, cmd_snt=0, resp_rdy=0, resp=8'h00, FSM=IDLE, receiver idle, RX sync flops preset to 1.
REQ-031 Reset asserted mid-transfer SHALL abort immediately, with TX high on the same cycle.
REQ-032 After reset release, no frame SHALL be emitted until a new snd_cmd.

Verification
REQ-033 snd_cmd with cmd=16'h7020 -> TX frames 0x70 then 0x20 LSB-first; cmd_snt rises 20*BAUD_CYC (+/-3) clocks after snd_cmd and stays high.
REQ-034 Drive RX with an 8N1 frame of 8'hA5 -> resp=8'hA5 and resp_rdy=1 about 9.5 to 10 bit-times after the start edge; then a frame of 8'h5A -> resp_rdy drops at its start bit and resp=8'h5A at its end.
REQ-035 Second snd_cmd (cmd=16'hFFFF) pulsed during the HIGH byte of 16'h0601 -> TX carries only 0x06, 0x01; one cmd_snt rise.
REQ-036 Loop TX back to RX, send 16'h1234 -> resp_rdy pulses twice, final resp=8'h34; cmd_snt=1.
REQ-037 rst_n low mid-LOW byte -> TX=1, cmd_snt=0 immediately; after release, a new snd_cmd of 16'hABCD transmits correctly.
